// File: rtl/core_defs.sv
// ----------------------------------------------------------------------------
// core_defs : shared core constants, instruction encodings and fetch FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package core_defs;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [XLEN-1:0] EBREAK_INSTR      = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register with load, hold and squash controls
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_id_reg
   import core_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            squash,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic [XLEN-1:0] fetch_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc_plus4,
   output logic [XLEN-1:0] ifid_instr,
   output logic            ifid_valid
);

   // A squash only turns the entry into a bubble; the PC fields keep their last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifid_pc       <= RESET_PC;
         ifid_pc_plus4 <= RESET_PC + 32'd4;
         ifid_instr    <= NOP_INSTR;
         ifid_valid    <= 1'b0;
      end else if (squash) begin
         ifid_instr    <= NOP_INSTR;
         ifid_valid    <= 1'b0;
      end else if (load) begin
         ifid_pc       <= fetch_pc;
         ifid_pc_plus4 <= fetch_pc + 32'd4;
         ifid_instr    <= fetch_instr;
         ifid_valid    <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit : RISC-V instruction fetch (PC, next-PC mux, BOOT/RUN/HALT FSM)
// Optional feature macro FETCH_PERF_CNT_EN adds the fetch_count port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import core_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid,
   output logic            halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] fetch_count
`endif
);

   fetch_state_t    state;
   fetch_state_t    next_state;
   logic [XLEN-1:0] next_pc;
   logic            ifid_load;
   logic            ifid_squash;
   logic            ebreak_latched;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};
   assign ebreak_latched       = if_id_valid && (if_id_instr == EBREAK_INSTR);
   assign halted               = (state == FETCH_HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH_BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= next_state;
         pc    <= next_pc;
      end
   end

   // Priority: redirect > stall > halt > normal advance.
   always_comb begin
      next_state  = state;
      next_pc     = pc;
      ifid_load   = 1'b0;
      ifid_squash = 1'b0;
      if (redirect) begin
         next_pc     = {redirect_pc[XLEN-1:2], 2'b00};
         ifid_squash = 1'b1;
         next_state  = FETCH_RUN;
      end else begin
         case (state)
            FETCH_BOOT: next_state = FETCH_RUN;
            FETCH_RUN: begin
               if (!stall) begin
                  if (ebreak_latched) begin
                     ifid_squash = 1'b1;
                     next_state  = FETCH_HALT;
                  end else begin
                     next_pc   = pc + 32'd4;
                     ifid_load = 1'b1;
                  end
               end
            end
            FETCH_HALT: ifid_squash = !stall;
            default:    next_state  = FETCH_BOOT;
         endcase
      end
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk           (clk),
      .reset         (reset),
      .load          (ifid_load),
      .squash        (ifid_squash),
      .fetch_pc      (pc),
      .fetch_instr   (instruction),
      .ifid_pc       (if_id_pc),
      .ifid_pc_plus4 (if_id_pc_plus4),
      .ifid_instr    (if_id_instr),
      .ifid_valid    (if_id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (ifid_load) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire
